// File: rtl/spad_frame_sequencer.sv
// SPAD frame sequencer: exposure/readout control, 32-pixel word packing, output word FIFO.
// Define SPAD_FRAME_SEQ_HEADER_EN to prepend a {16'hA5A5, frame_count} header word to every frame.
module spad_frame_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        continuous,
  input  logic [15:0] expose_cycles,
  output logic        ReadData,
  input  logic        ReadEnable,
  input  logic        HighLowRows,
  input  logic [2:0]  RowSelect,
  input  logic [5:0]  ColSelect,
  input  logic        pixel_in,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned PIX_W = 10;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ENT_W = WORD_W + 1;
`ifdef SPAD_FRAME_SEQ_HEADER_EN
  localparam logic [15:0] HDR_TAG = 16'hA5A5;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPOSE,
    S_READOUT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0]        r_exp_cnt;
  logic [PIX_W-1:0]   r_pix_cnt;
  logic [WORD_W-1:0]  r_word;
  logic               r_acc;
  logic               r_re_d;
  logic               r_frame_done;
  logic               r_wr_pend;
  logic [WORD_W-1:0]  r_wr_data;
  logic               r_wr_last;
  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic [15:0]        r_frame_count;
  logic               r_read_data;

  logic w_start_frame;
  logic w_enter_expose;
  logic w_enter_readout;
  logic w_exit_readout;
  logic w_commit;
  logic w_word_done;
  logic w_fifo_full;
  logic w_fifo_wr;
  logic w_fifo_rd;
  logic w_unused_rm;

  // Row/column addressing belongs to the read manager; only its enable/data matter here.
  assign w_unused_rm = ^{HighLowRows, RowSelect, ColSelect};

  // Next-state and transition strobes
  always_comb begin
    w_state_nxt     = r_state;
    w_start_frame   = 1'b0;
    w_enter_expose  = 1'b0;
    w_enter_readout = 1'b0;
    w_exit_readout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start || continuous) begin
          w_state_nxt    = S_EXPOSE;
          w_start_frame  = 1'b1;
          w_enter_expose = 1'b1;
        end
      end
      S_EXPOSE: begin
        if (r_exp_cnt == 16'd0) begin
          w_state_nxt     = S_READOUT;
          w_enter_readout = 1'b1;
        end
      end
      S_READOUT: begin
        if (r_frame_done) begin
          w_exit_readout = 1'b1;
          if (continuous) begin
            w_state_nxt    = S_EXPOSE;
            w_enter_expose = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A pixel commits on the falling edge of a ReadEnable phase; none after the 1024th.
  assign w_commit    = (r_state == S_READOUT) && r_re_d && !ReadEnable && !r_frame_done;
  assign w_word_done = w_commit && (&r_pix_cnt[4:0]);

  // Full is judged before any same-cycle read, so a write into a full FIFO always drops.
  assign w_fifo_full = (r_count == CW'(FIFO_DEPTH));
  assign w_fifo_wr   = r_wr_pend && !w_fifo_full;
  assign w_fifo_rd   = (r_count != '0) && m_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_read_data <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_read_data <= (w_state_nxt == S_READOUT);
    end
  end

  // Exposure length latched on entry; zero behaves as one clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_exp_cnt <= 16'd0;
    end else if (w_enter_expose) begin
      r_exp_cnt <= (expose_cycles == 16'd0) ? 16'd0 : (expose_cycles - 16'd1);
    end else if ((r_state == S_EXPOSE) && (r_exp_cnt != 16'd0)) begin
      r_exp_cnt <= r_exp_cnt - 16'd1;
    end
  end

  // Pixel accumulation and LSB-first word packing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc        <= 1'b0;
      r_re_d       <= 1'b0;
      r_pix_cnt    <= '0;
      r_word       <= '0;
      r_frame_done <= 1'b0;
    end else if (w_enter_readout) begin
      r_acc        <= 1'b0;
      r_re_d       <= 1'b0;
      r_pix_cnt    <= '0;
      r_word       <= '0;
      r_frame_done <= 1'b0;
    end else if (r_state == S_READOUT) begin
      r_re_d <= ReadEnable;
      r_acc  <= ReadEnable & (r_acc | pixel_in);
      if (w_commit) begin
        r_word[r_pix_cnt[4:0]] <= r_acc;
        r_pix_cnt              <= r_pix_cnt + PIX_W'(1);
        if (&r_pix_cnt) begin
          r_frame_done <= 1'b1;
        end
      end
    end else begin
      r_re_d <= 1'b0;
      r_acc  <= 1'b0;
    end
  end

  // One-deep write stage: completed words reach the FIFO on the following edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_pend <= 1'b0;
      r_wr_data <= '0;
      r_wr_last <= 1'b0;
    end else begin
      r_wr_pend <= 1'b0;
`ifdef SPAD_FRAME_SEQ_HEADER_EN
      if (w_enter_readout) begin
        r_wr_pend <= 1'b1;
        r_wr_data <= {HDR_TAG, r_frame_count};
        r_wr_last <= 1'b0;
      end
`endif
      if (w_word_done) begin
        r_wr_pend <= 1'b1;
        r_wr_data <= {r_acc, r_word[WORD_W-2:0]};
        r_wr_last <= &r_pix_cnt[PIX_W-1:5];
      end
    end
  end

  // Output FIFO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_mem[r_wr_ptr] <= {r_wr_last, r_wr_data};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_fifo_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag and frame counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_overflow    <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      if (w_start_frame) begin
        r_overflow <= 1'b0;
      end else if (r_wr_pend && w_fifo_full) begin
        r_overflow <= 1'b1;
      end
      if (w_exit_readout) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign ReadData    = r_read_data;
  assign m_valid     = (r_count != '0);
  assign m_data      = r_mem[r_rd_ptr][WORD_W-1:0];
  assign m_last      = r_mem[r_rd_ptr][WORD_W];
  assign busy        = (r_state != S_IDLE) || (r_count != '0);
  assign overflow    = r_overflow;
  assign frame_count = r_frame_count;

endmodule
